cv32e40p_x_responder: RTL and testbench
=======================================

CV32E40P_X_RESPONDER -- requirements
Module: cv32e40p_x_responder

Interface
REQ-001 The block SHALL have parameter COPROC_OPCODE, default 7'b0001011, giving the major opcode (instr[6:0]) the coprocessor accepts.
REQ-002 The block SHALL have parameter RESP_DEPTH, default 2, giving the number of result-buffer entries (legal range 1..4).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 x_valid_i  input  1  offload request valid.
REQ-006 x_ready_o  output  1  responder ready to take the request.
REQ-007 x_instr_data_i  input  32  offloaded instruction word.
REQ-008 x_rs_i  input  3x32  source operands rs1/rs2/rs3.
REQ-009 x_rs_valid_i  input  3  per-operand valid.
REQ-010 x_rd_clean_i  input  1  destination has no pending core write.
REQ-011 x_accept_o  output  1  instruction accepted (meaningful while x_valid_i & x_ready_o).
REQ-012 x_is_mem_op_o  output  1  always 0.
REQ-013 x_writeback_o  output  1  accepted instruction will return a result.
REQ-014 x_rvalid_o  output  1  response valid.
REQ-015 x_rready_i  input  1  core takes the response.
REQ-016 x_rd_o  output  5  destination register.
REQ-017 x_data_o  output  32  result data.
REQ-018 x_dualwb_o, x_type_o  output  1 each  always 0.
REQ-019 x_error_o  output  1  response carries an error.

Function
REQ-020 Decode: instr[6:0]==COPROC_OPCODE and funct3 in {000 ADD3, 001 XOR3, 010 MUL} SHALL mark the instruction supported; anything else unsupported.
REQ-021 Unsupported: x_ready_o=1, x_accept_o=0, x_writeback_o=0 in the same cycle as x_valid_i (when not busy); no response produced.
REQ-022 Supported: x_ready_o=1 only when required operands are valid (ADD3/XOR3: rs1..rs3; MUL: rs1,rs2), x_rd_clean_i=1, MUL engine idle, and (buffer occupancy + in-flight) < RESP_DEPTH; then x_accept_o=1.
REQ-023 x_writeback_o SHALL equal 1 for accepted instructions with rd=instr[11:7]!=0; rd==0 SHALL be executed but produce no response.
REQ-024 Handshake at cycle t (valid&ready&accept): ADD3 result = rs1+rs2+rs3 mod 2^32, XOR3 = rs1^rs2^rs3, pushed at edge ending t; x_rvalid_o visible at t+1.
REQ-025 MUL SHALL use an iterative shift-add engine, states IDLE->BUSY (32 iterations)->DONE->IDLE; low 32 bits of rs1*rs2 pushed so x_rvalid_o is visible at t+33.
REQ-026 While MUL is BUSY/DONE, x_ready_o SHALL be 0 for all requests, including unsupported ones.
REQ-027 funct7!=0 on a supported funct3 SHALL be accepted and return one response with x_error_o=1, x_data_o=0, single-cycle timing.
REQ-028 Result buffer: FIFO, in-order; head drives x_rvalid_o/x_rd_o/x_data_o/x_error_o; pop on x_rvalid_o & x_rready_i.
REQ-029 Head outputs SHALL remain stable while x_rvalid_o=1 and x_rready_i=0.
REQ-030 Full: ready computation SHALL ignore a same-cycle pop (conservative); simultaneous push and pop on non-full buffer keeps occupancy unchanged.
REQ-031 Pointers SHALL wrap modulo RESP_DEPTH.

Reset
REQ-032 While rst_ni=0: x_ready_o, x_accept_o, x_writeback_o, x_rvalid_o, x_error_o =0, x_rd_o=0, x_data_o=0; buffer empty; MUL engine IDLE.
REQ-033 Reset asserted mid-MUL or with buffered results SHALL discard them; no response after release.

Structure
REQ-034 Package cv32e40p_x_pkg SHALL hold the default opcode constant, funct3 op enum, MUL state enum, and response-entry struct {rd, data, error}.
REQ-035 The result buffer SHALL be the sub-module cv32e40p_x_resp_fifo; decode, ready logic and MUL engine live in the top.

Verification
REQ-036 ADD3 rs=1,2,3, rd=5, x_rready_i=1 -> accept at t, x_rvalid_o=1 at t+1, x_rd_o=5, x_data_o=6.
REQ-037 MUL rs1=7, rs2=6, rd=9 -> x_ready_o=0 t+1..t+33, response at t+33 with data 42; rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFE.
REQ-038 Opcode 7'b0110011 valid -> x_ready_o=1, x_accept_o=0 same cycle, no x_rvalid_o within 40 cycles.
REQ-039 x_rready_i=0, three back-to-back XOR3 -> two accepted, third sees x_ready_o=0 until first pop, then accepted; responses in order.
REQ-040 ADD3 funct7=0x01, rd=3 -> response x_error_o=1, x_data_o=0, x_rd_o=3.
REQ-041 rst_ni low at t+10 of a MUL -> all outputs 0, no response after release; next ADD3 behaves as REQ-036.

Source files
------------

// File: rtl/cv32e40p_x_pkg.sv
// rtl/cv32e40p_x_pkg.sv - shared types and constants for the X-interface responder
package cv32e40p_x_pkg;

  localparam logic [6:0] DEFAULT_OPCODE = 7'b0001011;

  typedef enum logic [2:0] {
    OP_ADD3 = 3'b000,
    OP_XOR3 = 3'b001,
    OP_MUL  = 3'b010
  } x_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        error;
  } resp_entry_t;

endpackage

// File: rtl/cv32e40p_x_resp_fifo.sv
// rtl/cv32e40p_x_resp_fifo.sv - in-order result buffer feeding the response channel
module cv32e40p_x_resp_fifo
  import cv32e40p_x_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head,
  output logic        not_empty,
  output logic [2:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 3'd1;
      else if (!push && pop) count <= count - 3'd1;
    end
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != 3'd0);

endmodule

// File: rtl/cv32e40p_x_responder.sv
// rtl/cv32e40p_x_responder.sv - coprocessor responder: decode, issue gating, shift-add MUL
module cv32e40p_x_responder
  import cv32e40p_x_pkg::*;
#(
  parameter logic [6:0] COPROC_OPCODE = DEFAULT_OPCODE,
  parameter int         RESP_DEPTH    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  input  logic [31:0]      x_instr_data_i,
  input  logic [2:0][31:0] x_rs_i,
  input  logic [2:0]       x_rs_valid_i,
  input  logic             x_rd_clean_i,
  output logic             x_accept_o,
  output logic             x_is_mem_op_o,
  output logic             x_writeback_o,
  output logic             x_rvalid_o,
  input  logic             x_rready_i,
  output logic [4:0]       x_rd_o,
  output logic [31:0]      x_data_o,
  output logic             x_dualwb_o,
  output logic             x_type_o,
  output logic             x_error_o
);

  mul_state_e  state;
  logic [4:0]  cnt;
  logic [31:0] acc, mcand, mplier;
  logic [4:0]  mul_rd;

  x_op_e       op;
  logic [4:0]  rd;
  logic        supported, is_mul, f7_bad, ops_ok, room, in_flight;
  logic        hs, start_mul, single_push, mul_push, pop;
  logic [31:0] acc_next, single_data;
  logic [2:0]  count;
  logic        not_empty;
  resp_entry_t head, push_entry;
  logic        unused_bits;

  assign unused_bits = ^x_instr_data_i[24:15];

  assign op        = x_op_e'(x_instr_data_i[14:12]);
  assign rd        = x_instr_data_i[11:7];
  assign f7_bad    = (x_instr_data_i[31:25] != 7'd0);
  assign is_mul    = (op == OP_MUL);
  assign supported = (x_instr_data_i[6:0] == COPROC_OPCODE) &&
                     (op == OP_ADD3 || op == OP_XOR3 || op == OP_MUL);
  assign ops_ok    = is_mul ? (&x_rs_valid_i[1:0]) : (&x_rs_valid_i);

  // Occupancy is the registered count, so a pop in the same cycle does not free a slot.
  assign in_flight = (state == MUL_BUSY) && (mul_rd != 5'd0);
  assign room      = (4'(count) + 4'(in_flight)) < 4'(RESP_DEPTH);

  assign x_ready_o     = rst_ni && (state == MUL_IDLE) &&
                         (!supported || (ops_ok && x_rd_clean_i && room));
  assign x_accept_o    = rst_ni && x_valid_i && supported;
  assign x_writeback_o = rst_ni && x_valid_i && supported && (rd != 5'd0);
  assign x_is_mem_op_o = 1'b0;
  assign x_dualwb_o    = 1'b0;
  assign x_type_o      = 1'b0;

  assign hs          = x_valid_i && x_ready_o && supported;
  assign start_mul   = hs && is_mul && !f7_bad;
  assign single_push = hs && (!is_mul || f7_bad) && (rd != 5'd0);
  assign single_data = f7_bad ? 32'd0 :
                       (op == OP_ADD3) ? (x_rs_i[0] + x_rs_i[1] + x_rs_i[2]) :
                                         (x_rs_i[0] ^ x_rs_i[1] ^ x_rs_i[2]);

  // The final iteration's sum is pushed directly so the response lands 33 cycles after issue.
  assign acc_next = acc + (mplier[0] ? mcand : 32'd0);
  assign mul_push = (state == MUL_BUSY) && (cnt == 5'd31) && (mul_rd != 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mul_rd <= '0;
    end else begin
      case (state)
        MUL_IDLE: if (start_mul) begin
          state  <= MUL_BUSY;
          cnt    <= '0;
          acc    <= '0;
          mcand  <= x_rs_i[0];
          mplier <= x_rs_i[1];
          mul_rd <= rd;
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= MUL_DONE;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  always_comb begin
    push_entry = '0;
    if (mul_push) begin
      push_entry.rd   = mul_rd;
      push_entry.data = acc_next;
    end else begin
      push_entry.rd    = rd;
      push_entry.data  = single_data;
      push_entry.error = f7_bad;
    end
  end

  assign pop = not_empty && x_rready_i;

  cv32e40p_x_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (single_push || mul_push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .not_empty  (not_empty),
    .count      (count)
  );

  assign x_rvalid_o = not_empty;
  assign x_rd_o     = not_empty ? head.rd : 5'd0;
  assign x_data_o   = not_empty ? head.data : 32'd0;
  assign x_error_o  = not_empty && head.error;

endmodule

// File: tb/tb_cv32e40p_x_responder.sv
// tb/tb_cv32e40p_x_responder.sv - self-checking bench for cv32e40p_x_responder
module tb_cv32e40p_x_responder;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             x_valid_i, x_ready_o;
  logic [31:0]      x_instr_data_i;
  logic [2:0][31:0] x_rs_i;
  logic [2:0]       x_rs_valid_i;
  logic             x_rd_clean_i, x_accept_o, x_is_mem_op_o, x_writeback_o;
  logic             x_rvalid_o, x_rready_i;
  logic [4:0]       x_rd_o;
  logic [31:0]      x_data_o;
  logic             x_dualwb_o, x_type_o, x_error_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cv32e40p_x_responder dut (
    .clk_i(clk), .rst_ni(rst_ni), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .x_instr_data_i(x_instr_data_i), .x_rs_i(x_rs_i), .x_rs_valid_i(x_rs_valid_i),
    .x_rd_clean_i(x_rd_clean_i), .x_accept_o(x_accept_o), .x_is_mem_op_o(x_is_mem_op_o),
    .x_writeback_o(x_writeback_o), .x_rvalid_o(x_rvalid_o), .x_rready_i(x_rready_i),
    .x_rd_o(x_rd_o), .x_data_o(x_data_o), .x_dualwb_o(x_dualwb_o), .x_type_o(x_type_o),
    .x_error_o(x_error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 10'h000, f3, rd, opc};
  endfunction

  // Reference: what the coprocessor should do with one instruction, from the ISA-level rules.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a, b, c,
                                output bit sup, output bit resp, output logic [31:0] data,
                                output bit err, output int lat);
    logic [63:0] p;
    sup  = (ins[6:0] == 7'b0001011) && (ins[14:12] <= 3'd2);
    resp = sup && (ins[11:7] != 5'd0);
    err  = sup && (ins[31:25] != 7'd0);
    lat  = (sup && ins[14:12] == 3'd2 && !err) ? 33 : 1;
    p    = 64'(a) * 64'(b);
    case (ins[14:12])
      3'd0:    data = a + b + c;
      3'd1:    data = a ^ b ^ c;
      default: data = p[31:0];
    endcase
    if (err) data = 32'd0;
  endfunction

  task automatic send(input logic [31:0] ins, input logic [31:0] a, b, c,
                      output bit acc_s, output bit wb_s);
    bit ok = 0;
    @(posedge clk); #1;
    x_instr_data_i = ins;
    x_rs_i = {c, b, a};
    x_valid_i = 1'b1;
    acc_s = 0;
    wb_s = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (x_ready_o) begin
        ok = 1;
        acc_s = x_accept_o;
        wb_s = x_writeback_o;
        break;
      end
    end
    @(posedge clk); #1;
    x_valid_i = 1'b0;
    if (!ok) chk("send_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (x_rvalid_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_rvalid(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (x_rvalid_o) seen++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(x_ready_o), 32'd0);
    chk({tag, "_accept"}, 32'(x_accept_o), 32'd0);
    chk({tag, "_wb"}, 32'(x_writeback_o), 32'd0);
    chk({tag, "_rvalid"}, 32'(x_rvalid_o), 32'd0);
    chk({tag, "_error"}, 32'(x_error_o), 32'd0);
    chk({tag, "_rd"}, 32'(x_rd_o), 32'd0);
    chk({tag, "_data"}, x_data_o, 32'd0);
  endtask

  task automatic add3_basic(input string tag);
    bit acc_s, wb_s;
    int lat;
    send(mk(7'd0, 3'd0, 5'd5, 7'b0001011), 32'd1, 32'd2, 32'd3, acc_s, wb_s);
    chk({tag, "_accept"}, 32'(acc_s), 32'd1);
    chk({tag, "_wb"}, 32'(wb_s), 32'd1);
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_rd"}, 32'(x_rd_o), 32'd5);
    chk({tag, "_data"}, x_data_o, 32'd6);
    chk({tag, "_err"}, 32'(x_error_o), 32'd0);
    @(negedge clk);
    chk({tag, "_popped"}, 32'(x_rvalid_o), 32'd0);
  endtask

  initial begin
    bit acc_s, wb_s, sup, resp, err;
    int lat, seen, first_ready;
    logic [31:0] ins, a, b, c, d, da, db, dc;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd;

    // Reset with a valid supported request present: everything must stay quiet.
    rst_ni = 1'b0;
    x_valid_i = 1'b1;
    x_instr_data_i = mk(7'd0, 3'd0, 5'd5, 7'b0001011);
    x_rs_i = '0;
    x_rs_valid_i = 3'b111;
    x_rd_clean_i = 1'b1;
    x_rready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_memop", 32'(x_is_mem_op_o), 32'd0);
    x_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;

    add3_basic("add3");

    // MUL 7*6: ready held low t+1..t+33 even for an unsupported request.
    send(mk(7'd0, 3'd2, 5'd9, 7'b0001011), 32'd7, 32'd6, 32'd0, acc_s, wb_s);
    chk("mul_accept", 32'(acc_s), 32'd1);
    x_instr_data_i = mk(7'd0, 3'd0, 5'd1, 7'b0110011);
    x_valid_i = 1'b1;
    first_ready = 0;
    lat = 0;
    d = 32'hDEAD_BEEF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (x_ready_o && first_ready == 0) first_ready = k;
      if (x_rvalid_o && lat == 0) begin
        lat = k;
        d = x_data_o;
        rd = x_rd_o;
      end
    end
    x_valid_i = 1'b0;
    chk("mul_busy_ready_first", 32'(first_ready), 32'd34);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul_data", d, 32'd42);
    chk("mul_rd", 32'(rd), 32'd9);

    send(mk(7'd0, 3'd2, 5'd4, 7'b0001011), 32'hFFFF_FFFF, 32'd2, 32'd0, acc_s, wb_s);
    wait_resp(lat);
    chk("mul_wrap_lat", 32'(lat), 32'd33);
    chk("mul_wrap_data", x_data_o, 32'hFFFF_FFFE);

    // Unsupported opcode: taken, not accepted, never answered.
    send(mk(7'd0, 3'd0, 5'd7, 7'b0110011), 32'd1, 32'd1, 32'd1, acc_s, wb_s);
    chk("unsup_accept", 32'(acc_s), 32'd0);
    chk("unsup_wb", 32'(wb_s), 32'd0);
    count_rvalid(40, seen);
    chk("unsup_no_resp", 32'(seen), 32'd0);

    // Operand / rd_clean gating, checked without letting a handshake happen.
    @(posedge clk); #1;
    x_valid_i = 1'b1;
    x_instr_data_i = mk(7'd0, 3'd0, 5'd2, 7'b0001011);
    x_rd_clean_i = 1'b0;
    @(negedge clk);
    chk("gate_rd_clean", 32'(x_ready_o), 32'd0);
    x_rd_clean_i = 1'b1;
    x_rs_valid_i = 3'b011;
    #1;
    chk("gate_add_rs3", 32'(x_ready_o), 32'd0);
    x_instr_data_i = mk(7'd0, 3'd2, 5'd2, 7'b0001011);
    #1;
    chk("gate_mul_no_rs3", 32'(x_ready_o), 32'd1);
    x_valid_i = 1'b0;
    x_rs_valid_i = 3'b111;

    // Back-to-back XOR3 with the consumer stalled: buffer fills at two entries.
    a = 32'h1234_5678; b = 32'h0F0F_0F0F; c = 32'hA5A5_0000;
    da = a ^ b ^ c;
    db = (a + 1) ^ b ^ c;
    dc = (a + 2) ^ b ^ c;
    x_rready_i = 1'b0;
    @(posedge clk); #1;
    x_valid_i = 1'b1;
    x_instr_data_i = mk(7'd0, 3'd1, 5'd1, 7'b0001011);
    x_rs_i = {c, b, a};
    @(negedge clk); chk("b2b_first_ready", 32'(x_ready_o), 32'd1);
    @(posedge clk); #1;
    x_instr_data_i = mk(7'd0, 3'd1, 5'd2, 7'b0001011);
    x_rs_i = {c, b, a + 32'd1};
    @(negedge clk); chk("b2b_second_ready", 32'(x_ready_o), 32'd1);
    @(posedge clk); #1;
    x_instr_data_i = mk(7'd0, 3'd1, 5'd3, 7'b0001011);
    x_rs_i = {c, b, a + 32'd2};
    @(negedge clk); chk("b2b_full_ready", 32'(x_ready_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_full_ready2", 32'(x_ready_o), 32'd0);
    chk("b2b_head_stable", x_data_o, da);
    @(posedge clk); #1;
    x_rready_i = 1'b1;
    @(negedge clk);
    chk("b2b_pop_ignored", 32'(x_ready_o), 32'd0);
    chk("b2b_head_a_rd", 32'(x_rd_o), 32'd1);
    @(posedge clk); #1;
    x_rready_i = 1'b0;
    @(negedge clk);
    chk("b2b_third_ready", 32'(x_ready_o), 32'd1);
    chk("b2b_head_b", x_data_o, db);
    @(posedge clk); #1;
    x_valid_i = 1'b0;
    x_rready_i = 1'b1;
    @(negedge clk); chk("b2b_resp_b", x_data_o, db);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_resp_c", x_data_o, dc);
    chk("b2b_resp_c_rd", 32'(x_rd_o), 32'd3);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_drained", 32'(x_rvalid_o), 32'd0);

    // funct7 != 0 on a supported op: error response, zero data.
    send(mk(7'h01, 3'd0, 5'd3, 7'b0001011), 32'd10, 32'd20, 32'd30, acc_s, wb_s);
    chk("err_accept", 32'(acc_s), 32'd1);
    wait_resp(lat);
    chk("err_lat", 32'(lat), 32'd1);
    chk("err_flag", 32'(x_error_o), 32'd1);
    chk("err_data", x_data_o, 32'd0);
    chk("err_rd", 32'(x_rd_o), 32'd3);

    // Reset in the middle of a MUL discards it.
    send(mk(7'd0, 3'd2, 5'd9, 7'b0001011), 32'd7, 32'd6, 32'd0, acc_s, wb_s);
    repeat (9) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    x_valid_i = 1'b1;
    x_instr_data_i = mk(7'd0, 3'd0, 5'd5, 7'b0001011);
    @(negedge clk);
    check_idle_outputs("midrst");
    x_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    count_rvalid(40, seen);
    chk("midrst_no_resp", 32'(seen), 32'd0);
    add3_basic("post_rst_add3");

    // Randomised instructions against the reference model.
    for (int i = 0; i < 24; i++) begin
      opc = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'b0001011;
      f3  = 3'($urandom_range(0, 3));
      f7  = ($urandom_range(0, 5) == 0) ? 7'h01 : 7'h00;
      rd  = 5'($urandom);
      a = $urandom; b = $urandom; c = $urandom;
      ins = mk(f7, f3, rd, opc);
      model(ins, a, b, c, sup, resp, d, err, lat);
      send(ins, a, b, c, acc_s, wb_s);
      chk($sformatf("rnd%0d_accept", i), 32'(acc_s), 32'(sup));
      chk($sformatf("rnd%0d_wb", i), 32'(wb_s), 32'(resp));
      if (resp) begin
        first_ready = lat;
        wait_resp(lat);
        chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(first_ready));
        chk($sformatf("rnd%0d_data", i), x_data_o, d);
        chk($sformatf("rnd%0d_rd", i), 32'(x_rd_o), 32'(rd));
        chk($sformatf("rnd%0d_err", i), 32'(x_error_o), 32'(err));
      end else begin
        count_rvalid(36, seen);
        chk($sformatf("rnd%0d_no_resp", i), 32'(seen), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
